// File: rtl/mem_arbiter.sv
// Two-master (CPU / IOP) arbiter for a single synchronous memory port.
// Ownership parks on the last owner. A waiting master takes over when the owner
// goes idle, or after the owner has had MAX_BURST grants while the other waited.
// Every handover spends one bubble cycle in which neither master is granted.
module mem_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic         clock,
    input  logic         reset,

    input  logic         cpu_req,
    input  logic [15:31] cpu_addr,
    input  logic [0:3]   cpu_we,
    input  logic [0:31]  cpu_wdata,
    output logic         cpu_gnt,
    output logic         cpu_rvalid,
    output logic [0:31]  cpu_rdata,

    input  logic         iop_req,
    input  logic [15:31] iop_addr,
    input  logic [0:3]   iop_we,
    input  logic [0:31]  iop_wdata,
    output logic         iop_gnt,
    output logic         iop_rvalid,
    output logic [0:31]  iop_rdata,

    output logic [15:31] mem_address,
    output logic [0:3]   mem_write_en,
    output logic [0:31]  mem_data_in,
    input  logic [0:31]  mem_data_out
);

    localparam int unsigned BurstW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST);

    typedef enum logic {
        OwnerCpu = 1'b0,
        OwnerIop = 1'b1
    } owner_e;

    owner_e            owner_q, owner_d;
    logic [BurstW-1:0] burst_q, burst_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              iop_rvalid_q, iop_rvalid_d;

    logic own_req;
    logic other_req;
    logic burst_full;
    logic switch_now;
    logic own_gnt;

    // Arbitration decision and grants for the current cycle.
    always_comb begin
        own_req    = (owner_q == OwnerIop) ? iop_req : cpu_req;
        other_req  = (owner_q == OwnerIop) ? cpu_req : iop_req;
        burst_full = (burst_q == BurstMax);
        // The handover edge is the bubble: the old owner is not granted in it,
        // and the new owner's grant can only follow once owner_q has flipped.
        switch_now = other_req & (~own_req | burst_full);
        own_gnt    = own_req & ~switch_now & ~reset;
        cpu_gnt    = own_gnt & (owner_q == OwnerCpu);
        iop_gnt    = own_gnt & (owner_q == OwnerIop);
    end

    // Next owner, burst count and read-return flags.
    always_comb begin
        owner_d      = owner_q;
        burst_d      = burst_q;
        cpu_rvalid_d = cpu_gnt & (cpu_we == 4'b0000);
        iop_rvalid_d = iop_gnt & (iop_we == 4'b0000);

        if (switch_now) begin
            owner_d = (owner_q == OwnerIop) ? OwnerCpu : OwnerIop;
            burst_d = '0;
        end else if (!other_req) begin
            // Uncontested traffic never counts toward a forced handover.
            burst_d = '0;
        end else if (own_gnt && !burst_full) begin
            burst_d = burst_q + BurstW'(1);
        end
    end

    // Memory port follows the owner; writes are only strobed on a real grant.
    always_comb begin
        mem_address  = (owner_q == OwnerIop) ? iop_addr  : cpu_addr;
        mem_data_in  = (owner_q == OwnerIop) ? iop_wdata : cpu_wdata;
        mem_write_en = 4'b0000;
        if (cpu_gnt) begin
            mem_write_en = cpu_we;
        end else if (iop_gnt) begin
            mem_write_en = iop_we;
        end
    end

    // Read data is the memory output itself; rvalid qualifies it per master.
    always_comb begin
        cpu_rdata  = mem_data_out;
        iop_rdata  = mem_data_out;
        cpu_rvalid = cpu_rvalid_q;
        iop_rvalid = iop_rvalid_q;
    end

    // State registers; reset also drops any read return still in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q      <= OwnerCpu;
            burst_q      <= '0;
            cpu_rvalid_q <= 1'b0;
            iop_rvalid_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            burst_q      <= burst_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            iop_rvalid_q <= iop_rvalid_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random two-master
// traffic checked against a transaction-level arbitration and memory model.
module tb_mem_arbiter;

    localparam int unsigned MaxBurst = 4;

    logic         clock;
    logic         reset;
    logic         cpu_req, iop_req;
    logic [15:31] cpu_addr, iop_addr;
    logic [0:3]   cpu_we, iop_we;
    logic [0:31]  cpu_wdata, iop_wdata;
    logic         cpu_gnt, iop_gnt, cpu_rvalid, iop_rvalid;
    logic [0:31]  cpu_rdata, iop_rdata;
    logic [15:31] mem_address;
    logic [0:3]   mem_write_en;
    logic [0:31]  mem_data_in;
    logic [0:31]  mem_data_out;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.MAX_BURST(MaxBurst)) dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_we       (cpu_we),
        .cpu_wdata    (cpu_wdata),
        .cpu_gnt      (cpu_gnt),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .iop_req      (iop_req),
        .iop_addr     (iop_addr),
        .iop_we       (iop_we),
        .iop_wdata    (iop_wdata),
        .iop_gnt      (iop_gnt),
        .iop_rvalid   (iop_rvalid),
        .iop_rdata    (iop_rdata),
        .mem_address  (mem_address),
        .mem_write_en (mem_write_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Power-on / reset contents of every word.
    function automatic logic [0:31] init_word(input int a);
        logic [7:0] b;
        b = a[7:0];
        if (a == 16) return 32'h1234_5678;
        return {b, ~b, 8'h5A, b ^ 8'h3C};
    endfunction

    // Synchronous memory: read data valid the cycle after the address edge.
    logic [0:31] dev_mem [0:255];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) dev_mem[i] <= init_word(i);
        end else begin
            mem_data_out <= dev_mem[mem_address[24:31]];
            for (int l = 0; l < 4; l++) begin
                if (mem_write_en[l])
                    dev_mem[mem_address[24:31]][8*l +: 8] <= mem_data_in[8*l +: 8];
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference model state (random phase).
    logic          m_req  [2];
    logic [15:31]  m_addr [2];
    logic [0:3]    m_we   [2];
    logic [0:31]   m_wd   [2];
    bit            exp_g  [2];
    bit            pend   [2];
    logic [0:31]   pend_d [2];
    int            m_owner, m_streak;
    logic [0:31]   ref_written [int];

    function automatic logic [0:31] ref_read(input int a);
        if (ref_written.exists(a)) return ref_written[a];
        return init_word(a);
    endfunction

    task automatic apply_masters();
        cpu_req = m_req[0]; cpu_addr = m_addr[0]; cpu_we = m_we[0]; cpu_wdata = m_wd[0];
        iop_req = m_req[1]; iop_addr = m_addr[1]; iop_we = m_we[1]; iop_wdata = m_wd[1];
    endtask

    initial begin
        logic [0:31] w;
        logic [0:31] iw;
        logic [15:31] last_addr;
        bit prev_cg, prev_ig, cg, ig;
        int p, o;
        bit mine, other, handover;
        logic [0:3] exp_we;

        // Reset with a CPU write pending: nothing may reach memory.
        reset = 1'b1;
        cpu_req = 1'b1; cpu_addr = 17'h10; cpu_we = 4'b1111; cpu_wdata = 32'hFFFF_FFFF;
        iop_req = 1'b0; iop_addr = '0; iop_we = '0; iop_wdata = '0;
        #4;
        check("reset_we", 32'(mem_write_en), 32'h0);
        check("reset_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        check("reset_iop_rvalid", 32'(iop_rvalid), 32'h0);

        // CPU read of 0x10.
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0; cpu_we = 4'b0000;
        #4;
        check("rd_cpu_gnt", 32'(cpu_gnt), 32'h1);
        check("rd_iop_gnt", 32'(iop_gnt), 32'h0);
        check("rd_addr", 32'(mem_address), 32'h10);
        check("rd_we", 32'(mem_write_en), 32'h0);

        // CPU byte-0 write to 0x20; read data of 0x10 returns in this cycle.
        @(negedge clock);
        cpu_addr = 17'h20; cpu_we = 4'b1000; cpu_wdata = 32'hAB00_0000;
        #4;
        check("rd_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        check("rd_cpu_rdata", cpu_rdata, 32'h1234_5678);
        check("rd_iop_rvalid", 32'(iop_rvalid), 32'h0);
        check("wr_cpu_gnt", 32'(cpu_gnt), 32'h1);
        check("wr_we", 32'(mem_write_en), 32'h8);
        check("wr_data", mem_data_in, 32'hAB00_0000);

        @(negedge clock);
        cpu_req = 1'b0; cpu_we = 4'b0000;
        #4;
        check("wr_no_rvalid", 32'(cpu_rvalid), 32'h0);
        check("wr_we_off", 32'(mem_write_en), 32'h0);
        w = dev_mem[32];
        iw = init_word(32);
        check("wr_byte0", 32'(w[0:7]), 32'hAB);
        check("wr_bytes123", 32'(w[8:31]), 32'(iw[8:31]));

        // Both masters request continuously: 4 CPU, bubble, 4 IOP, bubble.
        @(negedge clock);
        cpu_req = 1'b1; cpu_addr = 17'h10; cpu_we = 4'b0000;
        iop_req = 1'b1; iop_addr = 17'h11; iop_we = 4'b0000;
        prev_cg = 1'b0; prev_ig = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #4;
            p = i % 10;
            cg = (p < 4);
            ig = (p >= 5) && (p < 9);
            check($sformatf("burst_cpu_gnt[%0d]", i), 32'(cpu_gnt), 32'(cg));
            check($sformatf("burst_iop_gnt[%0d]", i), 32'(iop_gnt), 32'(ig));
            check($sformatf("burst_cpu_rvalid[%0d]", i), 32'(cpu_rvalid), 32'(prev_cg));
            check($sformatf("burst_iop_rvalid[%0d]", i), 32'(iop_rvalid), 32'(prev_ig));
            prev_cg = cg; prev_ig = ig;
            @(negedge clock);
        end

        // CPU goes idle while IOP requests: one bubble, then IOP.
        cpu_req = 1'b0; iop_addr = 17'h30;
        #4;
        check("drop_bubble_cpu", 32'(cpu_gnt), 32'h0);
        check("drop_bubble_iop", 32'(iop_gnt), 32'h0);
        @(negedge clock);
        #4;
        check("drop_iop_gnt", 32'(iop_gnt), 32'h1);
        check("drop_iop_addr", 32'(mem_address), 32'h30);

        // IOP alone: granted every cycle with reads returning one cycle later.
        last_addr = 17'h30;
        for (int j = 0; j < 10; j++) begin
            @(negedge clock);
            iop_addr = 17'h31 + 17'(j);
            #4;
            check($sformatf("solo_iop_gnt[%0d]", j), 32'(iop_gnt), 32'h1);
            check($sformatf("solo_cpu_gnt[%0d]", j), 32'(cpu_gnt), 32'h0);
            check($sformatf("solo_iop_rvalid[%0d]", j), 32'(iop_rvalid), 32'h1);
            check($sformatf("solo_cpu_rvalid[%0d]", j), 32'(cpu_rvalid), 32'h0);
            check($sformatf("solo_iop_rdata[%0d]", j), iop_rdata, init_word(int'(last_addr)));
            last_addr = iop_addr;
        end

        // Owner stayed IOP: a CPU request now pays the handover bubble.
        @(negedge clock);
        iop_req = 1'b0; cpu_req = 1'b1; cpu_addr = 17'h10; cpu_we = 4'b0000;
        #4;
        check("park_cpu_bubble", 32'(cpu_gnt), 32'h0);
        check("park_iop_rvalid", 32'(iop_rvalid), 32'h1);
        check("park_iop_rdata", iop_rdata, init_word(int'(last_addr)));
        @(negedge clock);
        #4;
        check("park_cpu_gnt", 32'(cpu_gnt), 32'h1);

        // Reset right after a CPU read grant kills the pending rvalid.
        @(posedge clock);
        #1;
        reset = 1'b1; cpu_we = 4'b1111;
        @(negedge clock);
        #4;
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        check("rst_iop_rvalid", 32'(iop_rvalid), 32'h0);
        check("rst_we", 32'(mem_write_en), 32'h0);
        @(negedge clock);
        reset = 1'b0; cpu_we = 4'b0000; iop_req = 1'b1; iop_we = 4'b0000;
        #4;
        check("post_rst_cpu_gnt", 32'(cpu_gnt), 32'h1);
        check("post_rst_iop_gnt", 32'(iop_gnt), 32'h0);
        check("post_rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);

        // Random traffic against the reference model.
        @(negedge clock);
        reset = 1'b1; cpu_req = 1'b0; iop_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        m_owner = 0; m_streak = 0;
        ref_written.delete();
        for (int k = 0; k < 2; k++) begin
            m_req[k] = 1'b0; m_addr[k] = 17'h40; m_we[k] = '0; m_wd[k] = '0;
            exp_g[k] = 1'b0; pend[k] = 1'b0; pend_d[k] = '0;
        end

        for (int c = 0; c < 400; c++) begin
            // A master with nothing outstanding may start a new transfer.
            for (int k = 0; k < 2; k++) begin
                if (exp_g[k] || !m_req[k]) begin
                    m_req[k]  = ($urandom_range(0, 3) != 0);
                    m_addr[k] = 17'h40 + 17'($urandom_range(0, 63));
                    m_we[k]   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                    m_wd[k]   = $urandom;
                end
            end
            apply_masters();
            #4;

            o        = m_owner;
            mine     = m_req[o];
            other    = m_req[1-o];
            handover = other && (!mine || (m_streak >= int'(MaxBurst)));
            exp_g[o]   = mine && !handover;
            exp_g[1-o] = 1'b0;
            exp_we = exp_g[0] ? m_we[0] : (exp_g[1] ? m_we[1] : 4'b0000);

            check("rnd_cpu_gnt", 32'(cpu_gnt), 32'(exp_g[0]));
            check("rnd_iop_gnt", 32'(iop_gnt), 32'(exp_g[1]));
            check("rnd_we", 32'(mem_write_en), 32'(exp_we));
            if (exp_g[o]) begin
                check("rnd_addr", 32'(mem_address), 32'(m_addr[o]));
                if (m_we[o] != 4'b0000) check("rnd_wdata", mem_data_in, m_wd[o]);
            end
            check("rnd_cpu_rvalid", 32'(cpu_rvalid), 32'(pend[0]));
            check("rnd_iop_rvalid", 32'(iop_rvalid), 32'(pend[1]));
            if (pend[0]) check("rnd_cpu_rdata", cpu_rdata, pend_d[0]);
            if (pend[1]) check("rnd_iop_rdata", iop_rdata, pend_d[1]);

            @(posedge clock);
            for (int k = 0; k < 2; k++) begin
                pend[k] = 1'b0;
                if (exp_g[k]) begin
                    if (m_we[k] == 4'b0000) begin
                        pend[k]   = 1'b1;
                        pend_d[k] = ref_read(int'(m_addr[k]));
                    end else begin
                        w = ref_read(int'(m_addr[k]));
                        for (int l = 0; l < 4; l++)
                            if (m_we[k][l]) w[8*l +: 8] = m_wd[k][8*l +: 8];
                        ref_written[int'(m_addr[k])] = w;
                    end
                end
            end
            if (handover) begin
                m_owner  = 1 - m_owner;
                m_streak = 0;
            end else if (!other) begin
                m_streak = 0;
            end else if (exp_g[o] && m_streak < int'(MaxBurst)) begin
                m_streak = m_streak + 1;
            end
            @(negedge clock);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4: consecutive grants to the owning master while the other master requests, before a forced switch.
REQ-002 SHALL have port clock  input  1  system clock, all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cpu_req  input  1  CPU memory request, held until granted.
REQ-005 SHALL have port cpu_addr  input  [15:31]  CPU word address.
REQ-006 SHALL have port cpu_we  input  [0:3]  CPU byte-lane write enables; all zero means read.
REQ-007 SHALL have port cpu_wdata  input  [0:31]  CPU write data.
REQ-008 SHALL have port cpu_gnt  output  1  CPU request accepted at this rising edge.
REQ-009 SHALL have port cpu_rvalid  output  1  CPU read data valid this cycle.
REQ-010 SHALL have port cpu_rdata  output  [0:31]  CPU read data.
REQ-011 SHALL have ports iop_req, iop_addr, iop_we, iop_wdata, iop_gnt, iop_rvalid, iop_rdata with the same directions, widths and meanings for the IOP.
REQ-012 SHALL have port mem_address  output  [15:31]  to memory.
REQ-013 SHALL have port mem_write_en  output  [0:3]  to memory.
REQ-014 SHALL have port mem_data_in  output  [0:31]  write data to memory.
REQ-015 SHALL have port mem_data_out  input  [0:31]  memory read data; synchronous, valid the cycle after the address edge.

Function
REQ-016 SHALL hold a 1-bit owner register (0 = CPU, 1 = IOP) and a burst counter, width clog2(MAX_BURST+1).
REQ-017 SHALL drive cpu_gnt = (owner==CPU) & cpu_req and iop_gnt = (owner==IOP) & iop_req, combinationally.
REQ-018 SHALL mux mem_address, mem_data_in from the owner's port at all times; mem_write_en = owner's we when that owner's gnt is high, else 4'b0000.
REQ-019 A transfer SHALL complete at a rising edge where req & gnt are both high; the master may change addr/we/wdata after that edge.
REQ-020 For a completed read (we == 0), rvalid of that master SHALL be high exactly one cycle later with rdata = mem_data_out; rvalid SHALL be low otherwise.
REQ-021 rdata SHALL be a direct copy of mem_data_out for both masters; meaningful only while rvalid is high.
REQ-022 Completed writes SHALL produce no rvalid.
REQ-023 Owner switch at a rising edge SHALL occur when the other master requests and either (a) the owner's req is low, or (b) the burst counter equals MAX_BURST.
REQ-024 Otherwise owner SHALL stay (parking on last owner when both idle).
REQ-025 A switch SHALL cost one cycle: gnt to the new owner first possible in the cycle after the switching edge, never in the same cycle as the old owner's gnt.
REQ-026 Burst counter SHALL increment (saturating at MAX_BURST) on each completed transfer by the owner while the other master requests; it SHALL clear on a switch or whenever the other master's req is low.
REQ-027 With only one master requesting, that master SHALL receive back-to-back grants every cycle without limit.
REQ-028 Both req high with equal standing SHALL resolve to the current owner; rvalid for a read completed just before a switch SHALL still be delivered to the original master.

Reset
REQ-029 While reset is high: owner = CPU, burst counter = 0, cpu_rvalid = iop_rvalid = 0, mem_write_en = 0 regardless of req.
REQ-030 Reset asserted mid-read SHALL suppress the pending rvalid; first post-reset grant goes to the CPU if cpu_req is high.

Verification
REQ-031 CPU-only: cpu_req=1, read addr 0x10 holding 0x12345678 -> cpu_gnt same cycle, cpu_rvalid next cycle, cpu_rdata=0x12345678.
REQ-032 CPU write addr 0x20, we=4'b1000, wdata=0xAB000000 -> mem_write_en=1000 for one cycle, byte 0 of word 0x20 = 0xAB, no rvalid.
REQ-033 Both request continuously, MAX_BURST=4 -> grant pattern CPU x4, idle x1, IOP x4, idle x1, repeating.
REQ-034 CPU drops req while IOP requests -> one bubble cycle, then iop_gnt; IOP read completed at that edge yields iop_rvalid next cycle, cpu_rvalid low.
REQ-035 IOP alone for 10 cycles -> 10 consecutive iop_gnt, no bubble, no forced switch; owner stays IOP afterward.
REQ-036 reset pulsed in the cycle after a CPU read grant -> cpu_rvalid stays 0, owner = CPU, mem_write_en = 0 during reset.
